// File: rtl/rx_frame_decoder.sv
`default_nettype none

`ifndef __REG_ADDR_WIDTH
`define __REG_ADDR_WIDTH 8
`endif
`ifndef __REG_DATA_WIDTH
`define __REG_DATA_WIDTH 16
`endif

// ============================================================================
//  Module   : rx_frame_decoder
//  Purpose  : Turns the PC-link byte stream into register-write transactions
//             on the simple address/data interface. A frame is one address
//             byte followed by DATA_BYTES data bytes, MSB first. A partial
//             frame that stalls for TIMEOUT_CYCLES clocks is dropped so a
//             lost byte cannot misalign the stream permanently.
//  Ports    : clk         - clock
//             rst         - synchronous reset, active-low
//             rx_data     - received byte, valid while rx_rdy is high
//             rx_rdy      - one-cycle strobe per received byte
//             si_addr     - address of the last completed frame
//             si_data     - data of the last completed frame
//             si_rdy      - one-cycle pulse per completed frame
//             busy_o      - high while a frame is partially received
//             frame_err_o - one-cycle pulse when a partial frame times out
//  Revision : 1.0 - initial release
// ============================================================================
module rx_frame_decoder #(
    parameter int REG_ADDR_WIDTH = `__REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = `__REG_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_rdy,
    output logic [REG_ADDR_WIDTH-1:0] si_addr,
    output logic [REG_DATA_WIDTH-1:0] si_data,
    output logic                      si_rdy,
    output logic                      busy_o,
    output logic                      frame_err_o
);

    localparam int c_DATA_BYTES = (REG_DATA_WIDTH + 7) / 8;
    localparam int c_SHIFT_W    = 8 * c_DATA_BYTES;
    localparam int c_IDX_W      = (c_DATA_BYTES > 1) ? $clog2(c_DATA_BYTES) : 1;
    localparam int c_CNT_W      = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_DATA_BYTES - 1);
    // The counter holds the number of idle DATA cycles seen so far; the edge
    // at which it already equals TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th
    // idle edge after the last accepted byte.
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_DATA = 1'b1;

    logic [0:0]                r_state;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [REG_ADDR_WIDTH-1:0] r_addr;
    logic [c_SHIFT_W-1:0]      r_shift;
    logic [c_SHIFT_W-1:0]      w_shift_next;

    // New byte enters at the bottom so the first data byte ends up as MSB.
    generate
        if (c_SHIFT_W > 8) begin : g_shift_multi
            assign w_shift_next = {r_shift[c_SHIFT_W-9:0], rx_data};
        end else begin : g_shift_single
            assign w_shift_next = rx_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_shift     <= '0;
            si_addr     <= '0;
            si_data     <= '0;
            si_rdy      <= 1'b0;
            busy_o      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            si_rdy      <= 1'b0;
            frame_err_o <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (rx_rdy) begin
                        r_addr  <= rx_data[REG_ADDR_WIDTH-1:0];
                        r_shift <= '0;
                        r_idx   <= '0;
                        r_state <= c_ST_DATA;
                        busy_o  <= 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (rx_rdy) begin
                        // A byte on the expiry edge takes priority over the timeout.
                        r_shift <= w_shift_next;
                        r_cnt   <= '0;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_ST_IDLE;
                            busy_o  <= 1'b0;
                            si_addr <= r_addr;
                            si_data <= w_shift_next[REG_DATA_WIDTH-1:0];
                            si_rdy  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state     <= c_ST_IDLE;
                        busy_o      <= 1'b0;
                        frame_err_o <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_decoder.sv
`default_nettype none

// ============================================================================
//  Module   : tb_rx_frame_decoder
//  Purpose  : Self-checking bench for rx_frame_decoder. Three instances with
//             different parameters share one byte stream; each is compared
//             every cycle against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;

    logic [7:0]  a0;  logic [15:0] d0;  logic r0, b0, e0;
    logic [7:0]  a1;  logic [15:0] d1;  logic r1, b1, e1;
    logic [3:0]  a2;  logic [11:0] d2;  logic r2, b2, e2;

    always #5 clk = ~clk;

    rx_frame_decoder u_dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .si_addr(a0), .si_data(d0), .si_rdy(r0), .busy_o(b0), .frame_err_o(e0)
    );

    rx_frame_decoder #(.TIMEOUT_CYCLES(8)) u_dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .si_addr(a1), .si_data(d1), .si_rdy(r1), .busy_o(b1), .frame_err_o(e1)
    );

    rx_frame_decoder #(.REG_ADDR_WIDTH(4), .REG_DATA_WIDTH(12), .TIMEOUT_CYCLES(16)) u_dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .si_addr(a2), .si_data(d2), .si_rdy(r2), .busy_o(b2), .frame_err_o(e2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-instance parameters as seen by the model.
    int p_db[3] = '{2, 2, 2};
    int p_dw[3] = '{16, 16, 12};
    int p_aw[3] = '{8, 8, 4};
    int p_to[3] = '{1000000, 8, 16};

    // Frame-level model state.
    bit              m_in[3];
    int              m_n[3];
    int              m_idle[3];
    longint unsigned m_val[3];
    longint unsigned m_lat[3];
    longint unsigned m_addr[3];
    longint unsigned m_data[3];
    bit              m_srdy[3];
    bit              m_err[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Applies the inputs that were present at the last clock edge.
    task automatic model_step(input int i);
        m_srdy[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (!rst) begin
            m_in[i] = 1'b0; m_n[i] = 0; m_idle[i] = 0;
            m_val[i] = 0; m_lat[i] = 0; m_addr[i] = 0; m_data[i] = 0;
        end else if (rx_rdy) begin
            m_idle[i] = 0;
            if (!m_in[i]) begin
                m_in[i]  = 1'b1;
                m_n[i]   = 0;
                m_val[i] = 0;
                m_lat[i] = longint'(rx_data) % (64'd1 << p_aw[i]);
            end else begin
                m_val[i] = m_val[i] * 256 + longint'(rx_data);
                m_n[i]++;
                if (m_n[i] == p_db[i]) begin
                    m_in[i]   = 1'b0;
                    m_addr[i] = m_lat[i];
                    m_data[i] = m_val[i] % (64'd1 << p_dw[i]);
                    m_srdy[i] = 1'b1;
                end
            end
        end else if (m_in[i]) begin
            m_idle[i]++;
            if (m_idle[i] == p_to[i]) begin
                m_in[i]   = 1'b0;
                m_idle[i] = 0;
                m_err[i]  = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) model_step(i);
        check("dut0.si_rdy", 64'(r0), 64'(m_srdy[0]));
        check("dut0.si_addr", 64'(a0), m_addr[0]);
        check("dut0.si_data", 64'(d0), m_data[0]);
        check("dut0.busy_o", 64'(b0), 64'(m_in[0]));
        check("dut0.frame_err_o", 64'(e0), 64'(m_err[0]));
        check("dut1.si_rdy", 64'(r1), 64'(m_srdy[1]));
        check("dut1.si_addr", 64'(a1), m_addr[1]);
        check("dut1.si_data", 64'(d1), m_data[1]);
        check("dut1.busy_o", 64'(b1), 64'(m_in[1]));
        check("dut1.frame_err_o", 64'(e1), 64'(m_err[1]));
        check("dut2.si_rdy", 64'(r2), 64'(m_srdy[2]));
        check("dut2.si_addr", 64'(a2), m_addr[2]);
        check("dut2.si_data", 64'(d2), m_data[2]);
        check("dut2.busy_o", 64'(b2), 64'(m_in[2]));
        check("dut2.frame_err_o", 64'(e2), 64'(m_err[2]));
    endtask

    task automatic send(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
        tick();
        rx_rdy  = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_rdy = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        rx_rdy = 1'b0;
        tick();
        rst    = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        tick();
        tick();
        check("reset_addr", 64'(a0), 64'h0);
        check("reset_data", 64'(d0), 64'h0);
        check("reset_busy", 64'(b0), 64'h0);
        rst = 1'b1;

        // Single frame, consecutive bytes.
        send(8'h03);
        check("tp1_busy_a", 64'(b0), 64'h1);
        send(8'h12);
        check("tp1_busy_b", 64'(b0), 64'h1);
        send(8'h34);
        check("tp1_rdy", 64'(r0), 64'h1);
        check("tp1_addr", 64'(a0), 64'h03);
        check("tp1_data", 64'(d0), 64'h1234);
        check("tp1_busy_c", 64'(b0), 64'h0);
        idle(2);

        // Two frames streamed back to back.
        send(8'h01); send(8'h00); send(8'h01);
        check("tp2_rdy1", 64'(r0), 64'h1);
        check("tp2_data1", 64'(d0), 64'h0001);
        send(8'h02); send(8'hAB); send(8'hCD);
        check("tp2_rdy2", 64'(r0), 64'h1);
        check("tp2_addr2", 64'(a0), 64'h02);
        check("tp2_data2", 64'(d0), 64'hABCD);
        idle(3);
        check("tp2_hold_addr", 64'(a0), 64'h02);
        check("tp2_hold_data", 64'(d0), 64'hABCD);

        // Timeout on the TIMEOUT_CYCLES=8 instance, then a byte in the error cycle.
        do_reset();
        send(8'h05); send(8'hFF);
        idle(7);
        check("tp3_no_err_yet", 64'(e1), 64'h0);
        idle(1);
        check("tp3_err", 64'(e1), 64'h1);
        check("tp3_busy", 64'(b1), 64'h0);
        check("tp3_no_rdy", 64'(r1), 64'h0);
        send(8'h07); send(8'h00); send(8'h09);
        check("tp3_rdy", 64'(r1), 64'h1);
        check("tp3_addr", 64'(a1), 64'h07);
        check("tp3_data", 64'(d1), 64'h0009);
        idle(2);

        // Byte on the expiry edge wins.
        do_reset();
        send(8'h05);
        idle(7);
        send(8'hAA);
        check("tp4_no_err", 64'(e1), 64'h0);
        send(8'hBB);
        check("tp4_rdy", 64'(r1), 64'h1);
        check("tp4_addr", 64'(a1), 64'h05);
        check("tp4_data", 64'(d1), 64'hAABB);
        idle(10);

        // Reset in the middle of a frame.
        send(8'h04); send(8'h11);
        do_reset();
        check("tp5_addr0", 64'(a0), 64'h0);
        check("tp5_data0", 64'(d0), 64'h0);
        check("tp5_busy0", 64'(b0), 64'h0);
        check("tp5_err0", 64'(e0), 64'h0);
        send(8'h06); send(8'h22); send(8'h33);
        check("tp5_addr", 64'(a0), 64'h06);
        check("tp5_data", 64'(d0), 64'h2233);

        // 12-bit data / 4-bit address instance.
        do_reset();
        send(8'h02); send(8'hF1); send(8'h23);
        check("tp6_rdy", 64'(r2), 64'h1);
        check("tp6_addr", 64'(a2), 64'h2);
        check("tp6_data", 64'(d2), 64'h123);
        idle(2);

        // Randomised bursts and gaps; long gaps exercise the timeouts.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(6, 20));
            else idle($urandom_range(0, 3));
            for (int k = $urandom_range(1, 6); k > 0; k--)
                send(8'($urandom_range(0, 255)));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_frame_decoder.md
# rx_frame_decoder

Converts the byte stream arriving from the PC link into register-write transactions on the simple address/data interface (addr, data, rdy) consumed by the register file and the requests handler. Each frame is one address byte followed by the data bytes, MSB first. An inter-byte timeout discards partial frames so a lost byte cannot permanently misalign the stream. The block sits between the PC-link receiver and every register/request block on the simple interface.

## Interface
Parameters:
- REG_ADDR_WIDTH, default `__REG_ADDR_WIDTH (8): address width on the simple interface; must be ≤ 8.
- REG_DATA_WIDTH, default `__REG_DATA_WIDTH (16): data width on the simple interface; DATA_BYTES = (REG_DATA_WIDTH+7)/8.
- TIMEOUT_CYCLES, default 1000000: idle clocks allowed between bytes of one frame; must be ≥ 2.

Ports:
- clk  in  1  fpga clock.
- rst  in  1  reset; synchronous, active-low.
- rx_data  in  8  received byte, valid when rx_rdy = 1.
- rx_rdy  in  1  one-cycle strobe per received byte.
- si_addr  out  REG_ADDR_WIDTH  address of last completed frame.
- si_data  out  REG_DATA_WIDTH  data of last completed frame.
- si_rdy  out  1  one-cycle pulse per completed frame.
- busy_o  out  1  high while a frame is partially received.
- frame_err_o  out  1  one-cycle pulse when a partial frame is dropped by timeout.

## Operation
- States: IDLE (waiting for address byte), DATA (collecting data bytes; byte index k = 0..DATA_BYTES-1).
- IDLE, rx_rdy = 1: latch rx_data[REG_ADDR_WIDTH-1:0] into an internal address register, clear the data shift register, k ← 0, go to DATA. Upper address bits are ignored.
- DATA, rx_rdy = 1: shift register ← {shift[..], rx_data}. If k = DATA_BYTES-1, go to IDLE next cycle, load si_addr ← latched address and si_data ← low REG_DATA_WIDTH bits of the assembled value, and pulse si_rdy. Otherwise k ← k+1.
- si_addr/si_data hold their value between frames and change only when si_rdy is pulsed.
- Timeout counter: cleared on every accepted byte and while in IDLE. It increments each DATA cycle with rx_rdy = 0. If it reaches TIMEOUT_CYCLES-1 with rx_rdy = 0, then: go to IDLE, pulse frame_err_o, leave si_* unchanged, and do not pulse si_rdy.
- Simultaneous timeout expiry and rx_rdy: the byte wins. It is accepted normally and no error is raised.
- busy_o = (state == DATA).
- Reset (rst = 0 at a clk edge): state IDLE, k = 0, counter = 0, si_addr = 0, si_data = 0, si_rdy = 0, busy_o = 0, frame_err_o = 0. A partial frame in progress is discarded silently, with no frame_err_o.

## Timing
- All outputs are registered.
- si_rdy rises in the cycle after the clk edge that samples the last data byte, and stays high for exactly 1 cycle.
- si_addr and si_data are valid in the same cycle as si_rdy.
- Back-to-back bytes (rx_rdy high every cycle) are fully supported. The address byte of frame n+1 may arrive in the same cycle that si_rdy is high for frame n.
- frame_err_o rises in the cycle after the expiring edge, so it comes TIMEOUT_CYCLES clocks after the last accepted byte of the partial frame. It lasts 1 cycle, and busy_o falls in that same cycle.
- A byte arriving in the same cycle as frame_err_o is treated as a new address byte.

## Test plan
- Default parameters. Bytes 0x03, 0x12, 0x34 on consecutive cycles → one si_rdy pulse with si_addr = 0x03 and si_data = 0x1234, one cycle after the 0x34 strobe. busy_o is high for 2 cycles.
- Two frames streamed with no gap: 0x01 0x00 0x01 0x02 0xAB 0xCD → si_rdy pulses 3 cycles apart, carrying (0x01, 0x0001) then (0x02, 0xABCD). si_* hold (0x02, 0xABCD) afterwards.
- TIMEOUT_CYCLES = 8. Send 0x05, 0xFF, then nothing → frame_err_o pulses once, 8 cycles after 0xFF, with no si_rdy. Then 0x07 0x00 0x09 → (0x07, 0x0009).
- TIMEOUT_CYCLES = 8. Send 0x05, then 0xAA exactly on the expiry cycle, then 0xBB → no frame_err_o; si_rdy with (0x05, 0xAABB).
- Send 0x04, 0x11, assert rst = 0 for 1 cycle, then send 0x06 0x22 0x33 → outputs are zero after reset, no frame_err_o, and the next frame decodes as (0x06, 0x2233).
- REG_DATA_WIDTH = 12. Bytes 0x02, 0xF1, 0x23 → si_data = 0x123, with the upper nibble dropped.
